// File: rtl/led_cnt_pkg.sv
// Shared encodings for the multi-mode LED pattern counter.
package led_cnt_pkg;

  // Display mode selected by the mode input
  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_ROT    = 2'b11
  } mode_e;

  // Travel direction of the bounce pattern
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_counter_multi_tick_gen.sv
// Prescaler producing a one-cycle advance strobe every DIV_CYCLES enabled clocks.
module tick_gen #(
  parameter int DIV_CYCLES = 100_000_000,
  parameter int PRE_W      = 27
) (
  input  logic clk,
  input  logic res_n,
  input  logic en,
  input  logic clr,
  output logic pt
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV_CYCLES - 1);
  localparam logic [PRE_W-1:0] INC  = PRE_W'(1);

  logic [PRE_W-1:0] cnt_q;

  // Strobe on the last count of the period; a paused prescaler never strobes
  assign pt = en && (cnt_q == LAST);

  // Count enabled cycles; a parallel load restarts the period from zero
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= pt ? '0 : cnt_q + INC;
    end
  end

endmodule

// File: rtl/led_counter_multi.sv
// Multi-mode LED pattern counter: up, down, bounce and rotate with pause,
// manual step, parallel load and registered tick/wrap indications.
module led_counter_multi
  import led_cnt_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIV_CYCLES = 100_000_000,
  parameter int PRE_W      = 27
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] LD,
  output logic             tick,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX    = '1;
  localparam logic [WIDTH-1:0] MAX_M1 = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] ld_q, ld_d;
  dir_e             dir_q, dir_d;
  logic             tick_q;
  logic             wrap_q, wrap_d;
  logic             pt, adv, ld_onehot;

  tick_gen #(
    .DIV_CYCLES (DIV_CYCLES),
    .PRE_W      (PRE_W)
  ) u_tick_gen (
    .clk   (clk),
    .res_n (res_n),
    .en    (en),
    .clr   (load),
    .pt    (pt)
  );

  // A manual step coinciding with the prescaler strobe still yields one advance
  assign adv       = pt | step;
  assign ld_onehot = (ld_q != '0) && ((ld_q & (ld_q - ONE)) == '0);

  // Next pattern, direction and wrap flag for an advance in the current mode
  always_comb begin
    ld_d   = ld_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    case (mode_e'(mode))
      MODE_UP: begin
        ld_d   = ld_q + ONE;
        wrap_d = (ld_q == MAX);
      end
      MODE_DOWN: begin
        ld_d   = ld_q - ONE;
        wrap_d = (ld_q == '0);
      end
      MODE_BOUNCE: begin
        if (dir_q == DIR_UP) begin
          if (ld_q == MAX) begin
            ld_d   = MAX_M1;
            dir_d  = DIR_DOWN;
            wrap_d = 1'b1;
          end else begin
            ld_d = ld_q + ONE;
          end
        end else begin
          if (ld_q == '0) begin
            ld_d   = ONE;
            dir_d  = DIR_UP;
            wrap_d = 1'b1;
          end else begin
            ld_d = ld_q - ONE;
          end
        end
      end
      MODE_ROT: begin
        // A corrupted (non one-hot) pattern is re-seeded rather than rotated
        if (ld_onehot) begin
          ld_d   = {ld_q[WIDTH-2:0], ld_q[WIDTH-1]};
          wrap_d = ld_q[WIDTH-1];
        end else begin
          ld_d = ONE;
        end
      end
      default: begin
        ld_d = ld_q;
      end
    endcase
  end

  // Pattern, direction and indication registers; load wins over any advance
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ld_q   <= '0;
      dir_q  <= DIR_UP;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (load) begin
      ld_q   <= load_val;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (adv) begin
      ld_q   <= ld_d;
      dir_q  <= dir_d;
      tick_q <= 1'b1;
      wrap_q <= wrap_d;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end
  end

  assign LD   = ld_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule
